// File: rtl/epochtv1_pkg.sv
// Shared types and constants for the Epoch TV-1 video path.
package epochtv1_pkg;

  localparam int EPOCHTV1_MAX_COLS = 512;

  typedef struct packed {
    logic        de;
    logic [23:0] rgb;
  } epochtv1_px_t;

endpackage

// File: rtl/epochtv1_linebuf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module epochtv1_linebuf #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 25
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/epochtv1_scandoubler.sv
// 15 kHz -> 31 kHz line doubler with a ping-pong line buffer; output lags input by one line.
// Optional EPOCHTV1_SCANLINES_EN halves RGB on the second copy of each line.
module epochtv1_scandoubler
  import epochtv1_pkg::*;
#(
  parameter int MAX_COLS = EPOCHTV1_MAX_COLS,
  parameter int COL_W    = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        CE_2X,
  input  logic [23:0] RGB_I,
  input  logic        DE_I,
  input  logic        HS_I,
  input  logic        VS_I,
  input  logic        VBL_I,
  output logic [23:0] RGB_O,
  output logic        DE_O,
  output logic        HS_O,
  output logic        VS_O,
  output logic        VBL_O
);

  localparam int CW = COL_W + 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COLS);
  localparam logic [CW-1:0] ONE   = CW'(1);

  // input side
  logic          hs_d_reg;
  logic          ibank_reg;
  logic [CW-1:0] icol_reg;
  logic [CW-1:0] hsw_reg;
  logic          primed_reg;
  logic          vs_hold_reg;
  logic          vbl_hold_reg;

  // output side
  logic          obank_reg;
  logic          ohalf_reg;
  logic [CW-1:0] ocol_reg;
  logic [CW-1:0] olen_reg;
  logic [CW-1:0] ohsw_reg;
  logic          ovs_reg;
  logic          ovbl_reg;

  // read stage, aligned with the buffer word
  logic          rd_valid_reg;
  logic          rd_hs_reg;
  logic          rd_vs_reg;
  logic          rd_vbl_reg;

  logic          hs_rise;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic [CW-1:0] waddr;
  logic [CW-1:0] raddr;
  logic [CW-1:0] olen_m1;
  logic [23:0]   rgb_sel;
  epochtv1_px_t  wr_px;
  epochtv1_px_t  rd_px;

  assign hs_rise   = CE & HS_I & ~hs_d_reg;
  assign in_range  = icol_reg < MAX_C;
  assign wr_en     = CE & (hs_rise | in_range);
  // The pixel that carries the rising edge is column 0 of the freshly selected bank.
  assign waddr     = hs_rise ? {~ibank_reg, {COL_W{1'b0}}} : {ibank_reg, icol_reg[COL_W-1:0]};
  assign rd_en     = CE_2X & ~hs_rise;
  assign raddr     = {obank_reg, ocol_reg[COL_W-1:0]};
  assign olen_m1   = olen_reg - ONE;
  assign wr_px.de  = DE_I;
  assign wr_px.rgb = RGB_I;

  epochtv1_linebuf #(
    .ADDR_W(CW),
    .DATA_W($bits(epochtv1_px_t))
  ) u_linebuf (
    .CLK  (CLK),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(wr_px),
    .re   (rd_en),
    .raddr(raddr),
    .rdata(rd_px)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_d_reg     <= 1'b0;
      ibank_reg    <= 1'b0;
      icol_reg     <= '0;
      hsw_reg      <= '0;
      primed_reg   <= 1'b0;
      vs_hold_reg  <= 1'b0;
      vbl_hold_reg <= 1'b0;
    end else if (CE) begin
      hs_d_reg <= HS_I;
      if (hs_rise) begin
        ibank_reg    <= ~ibank_reg;
        icol_reg     <= ONE;
        hsw_reg      <= ONE;
        primed_reg   <= 1'b1;
        vs_hold_reg  <= VS_I;
        vbl_hold_reg <= VBL_I;
      end else begin
        if (in_range) icol_reg <= icol_reg + ONE;
        if (HS_I && hsw_reg < MAX_C) hsw_reg <= hsw_reg + ONE;
      end
    end
  end

  // A line cut short by reset is never replayed: the first rise after reset yields an idle line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      obank_reg    <= 1'b0;
      ohalf_reg    <= 1'b0;
      ocol_reg     <= '0;
      olen_reg     <= '0;
      ohsw_reg     <= '0;
      ovs_reg      <= 1'b0;
      ovbl_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_hs_reg    <= 1'b0;
      rd_vs_reg    <= 1'b0;
      rd_vbl_reg   <= 1'b0;
    end else if (hs_rise) begin
      ocol_reg  <= '0;
      ohalf_reg <= 1'b0;
      olen_reg  <= primed_reg ? icol_reg : '0;
      ohsw_reg  <= primed_reg ? hsw_reg : '0;
      obank_reg <= ibank_reg;
      ovs_reg   <= vs_hold_reg;
      ovbl_reg  <= vbl_hold_reg;
    end else if (CE_2X) begin
      if (ocol_reg == olen_m1) begin
        ocol_reg  <= '0;
        ohalf_reg <= ~ohalf_reg;
      end else begin
        ocol_reg <= ocol_reg + ONE;
      end
      rd_valid_reg <= (olen_reg != '0) && (ocol_reg < MAX_C);
      rd_hs_reg    <= ocol_reg < ohsw_reg;
      rd_vs_reg    <= ovs_reg;
      rd_vbl_reg   <= ovbl_reg;
    end
  end

`ifdef EPOCHTV1_SCANLINES_EN
  logic        rd_half_reg;
  logic [23:0] rgb_dim;

  always_ff @(posedge CLK) begin
    if (RST) rd_half_reg <= 1'b0;
    else if (rd_en) rd_half_reg <= ohalf_reg;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dim
      assign rgb_dim[gi*8 +: 8] = {1'b0, rd_px.rgb[gi*8+1 +: 7]};
    end
  endgenerate

  assign rgb_sel = rd_half_reg ? rgb_dim : rd_px.rgb;
`else
  assign rgb_sel = rd_px.rgb;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      RGB_O <= '0;
      DE_O  <= 1'b0;
      HS_O  <= 1'b0;
      VS_O  <= 1'b0;
      VBL_O <= 1'b0;
    end else begin
      RGB_O <= rd_valid_reg ? rgb_sel : 24'h0;
      DE_O  <= rd_valid_reg & rd_px.de;
      HS_O  <= rd_hs_reg;
      VS_O  <= rd_vs_reg;
      VBL_O <= rd_vbl_reg;
    end
  end

endmodule

// File: tb/tb_epochtv1_scandoubler.sv
// Directed bench for epochtv1_scandoubler: spot-check table plus per-line stream checks.
module tb_epochtv1_scandoubler;

  logic        CLK = 1'b0;
  logic        RST, CE, CE_2X, DE_I, HS_I, VS_I, VBL_I;
  logic [23:0] RGB_I;
  logic [23:0] RGB_O;
  logic        DE_O, HS_O, VS_O, VBL_O;

  always #5 CLK = ~CLK;

  epochtv1_scandoubler dut (
    .CLK(CLK), .RST(RST), .CE(CE), .CE_2X(CE_2X),
    .RGB_I(RGB_I), .DE_I(DE_I), .HS_I(HS_I), .VS_I(VS_I), .VBL_I(VBL_I),
    .RGB_O(RGB_O), .DE_O(DE_O), .HS_O(HS_O), .VS_O(VS_O), .VBL_O(VBL_O)
  );

  localparam int NL   = 10;
  localparam int MAXT = 1200;
  localparam int RST_LINE = 6;
  localparam int RST_COL  = 100;

`ifdef EPOCHTV1_SCANLINES_EN
  localparam bit SL = 1'b1;
  localparam logic [23:0] H1_28 = 24'h507F00, H1_259 = 24'h000001;
  localparam logic [23:0] H1_120 = 24'h01003C, H1_40 = 24'h040014;
`else
  localparam bit SL = 1'b0;
  localparam logic [23:0] H1_28 = 24'hA1FF00, H1_259 = 24'h010103;
  localparam logic [23:0] H1_120 = 24'h020078, H1_40 = 24'h080028;
`endif

  typedef struct { int len; bit vs; bit vbl; } line_t;
  typedef struct packed { logic [23:0] rgb; logic de; logic hs; logic vs; logic vbl; } out_t;
  typedef struct { int ln; int t; logic [23:0] rgb; logic de; logic hs; logic vs; logic vbl; } spot_t;

  line_t lines [NL];
  spot_t spots [18];
  out_t  cap [NL][MAXT];
  int    ntick [NL];
  int    cur_line, pend_line, rst_tick;
  bit    pend;
  int    n_checks = 0, n_fail = 0;

  function automatic logic [23:0] px_rgb(input int ln, input int col);
    logic [7:0]  l8;
    logic [15:0] c16;
    l8  = ln[7:0];
    c16 = col[15:0];
    if (col < 24) return 24'h0;
    if (col == 28) return 24'hA1FF00;
    return {l8, c16};
  endfunction

  // One CLK; the sample taken after it belongs to the line whose CE_2X caused the read.
  task automatic clk1(input bit rst, input bit ce, input bit ce2x);
    RST = rst; CE = ce; CE_2X = ce2x;
    @(posedge CLK);
    @(negedge CLK);
    if (pend && pend_line >= 0 && ntick[pend_line] < MAXT) begin
      cap[pend_line][ntick[pend_line]] = {RGB_O, DE_O, HS_O, VS_O, VBL_O};
      ntick[pend_line]++;
    end
    pend = ce2x;
    pend_line = cur_line;
  endtask

  task automatic run_line(input int k);
    cur_line = k;
    for (int col = 0; col < lines[k].len; col++) begin
      RGB_I = px_rgb(k, col);
      DE_I  = (col >= 24);
      HS_I  = (col < 20);
      VS_I  = lines[k].vs;
      VBL_I = lines[k].vbl;
      clk1(1'b0, 1'b1, 1'b0);
      clk1(1'b0, 1'b0, 1'b1);
      if (k == RST_LINE && col == RST_COL) begin
        clk1(1'b1, 1'b0, 1'b0);
        n_checks++;
        rst_tick = ntick[k] - 1;
        if ({RGB_O, DE_O, HS_O, VS_O, VBL_O} !== 28'h0)
          $display("FAIL reset_mid_line got %h want 0", {RGB_O, DE_O, HS_O, VS_O, VBL_O});
        if ({RGB_O, DE_O, HS_O, VS_O, VBL_O} !== 28'h0) n_fail++;
      end else begin
        clk1(1'b0, 1'b0, 1'b0);
      end
      clk1(1'b0, 1'b0, 1'b1);
    end
  endtask

  // Output during input line k replays line k-1: col = t mod len, half = (t div len) mod 2.
  task automatic check_stream(input int k);
    int   olen, col, half, bad;
    out_t e;
    olen = (lines[k-1].len > 512) ? 512 : lines[k-1].len;
    bad  = -1;
    e    = '0;
    for (int t = 0; t < 2 * lines[k].len; t++) begin
      col   = t % olen;
      half  = (t / olen) % 2;
      e.rgb = px_rgb(k - 1, col);
      if (SL && half == 1) e.rgb = (e.rgb >> 1) & 24'h7F7F7F;
      e.de  = (col >= 24);
      e.hs  = (col < 20);
      e.vs  = lines[k-1].vs;
      e.vbl = lines[k-1].vbl;
      if (bad < 0 && cap[k][t] !== e) bad = t;
    end
    n_checks++;
    if (ntick[k] != 2 * lines[k].len || bad >= 0) begin
      n_fail++;
      if (bad >= 0)
        $display("FAIL stream line %0d tick %0d got %h want %h", k, bad, cap[k][bad], e);
      else
        $display("FAIL stream line %0d ticks got %0d want %0d", k, ntick[k], 2 * lines[k].len);
    end else begin
      $display("line %0d stream ok (%0d ticks)", k, ntick[k]);
    end
  endtask

  task automatic check_idle(input int k);
    int bad;
    bad = -1;
    for (int t = 0; t < ntick[k]; t++)
      if (bad < 0 && cap[k][t] !== '0) bad = t;
    n_checks++;
    if (bad >= 0 || ntick[k] != 2 * lines[k].len) begin
      n_fail++;
      $display("FAIL idle line %0d tick %0d got %h want 0 (ticks %0d)", k, bad, (bad >= 0) ? cap[k][bad] : '0, ntick[k]);
    end else begin
      $display("line %0d idle ok", k);
    end
  endtask

  initial begin
    int   de_cnt, hs_pulses;
    out_t a, e;

    for (int k = 0; k < NL; k++) begin
      lines[k] = '{260, 1'b0, 1'b0};
      ntick[k] = 0;
    end
    lines[1] = '{260, 1'b1, 1'b1};
    lines[3] = '{600, 1'b0, 1'b0};

    spots[0]  = '{0, 100, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0};
    spots[1]  = '{1,   0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    spots[2]  = '{2,  28, 24'hA1FF00, 1'b1, 1'b0, 1'b1, 1'b1};
    spots[3]  = '{2, 288, H1_28,      1'b1, 1'b0, 1'b1, 1'b1};
    spots[4]  = '{2,  19, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1};
    spots[5]  = '{2,  20, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1};
    spots[6]  = '{2,  24, 24'h010018, 1'b1, 1'b0, 1'b1, 1'b1};
    spots[7]  = '{2, 279, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1};
    spots[8]  = '{2, 519, H1_259,     1'b1, 1'b0, 1'b1, 1'b1};
    spots[9]  = '{3,   0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    spots[10] = '{3, 620, 24'h020064, 1'b1, 1'b0, 1'b0, 1'b0};
    spots[11] = '{3, 900, H1_120,     1'b1, 1'b0, 1'b0, 1'b0};
    spots[12] = '{4, 511, 24'h0301FF, 1'b1, 1'b0, 1'b0, 1'b0};
    spots[13] = '{4, 512, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    spots[14] = '{4,  28, 24'hA1FF00, 1'b1, 1'b0, 1'b0, 1'b0};
    spots[15] = '{5, 260, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0};
    spots[16] = '{5, 259, 24'h040103, 1'b1, 1'b0, 1'b0, 1'b0};
    spots[17] = '{9, 300, H1_40,      1'b1, 1'b0, 1'b0, 1'b0};

    cur_line = -1; pend_line = -1; pend = 1'b0; rst_tick = 0;
    RGB_I = '0; DE_I = 0; HS_I = 0; VS_I = 0; VBL_I = 0;

    repeat (3) clk1(1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({RGB_O, DE_O, HS_O, VS_O, VBL_O} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h want 0", {RGB_O, DE_O, HS_O, VS_O, VBL_O});
    end else begin
      $display("reset state ok");
    end
    repeat (4) clk1(1'b0, 1'b0, 1'b0);

    for (int k = 0; k < NL; k++) run_line(k);
    cur_line = -1;
    repeat (4) clk1(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      a = cap[spots[i].ln][spots[i].t];
      e = {spots[i].rgb, spots[i].de, spots[i].hs, spots[i].vs, spots[i].vbl};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL spot[%0d] line %0d tick %0d got %h want %h", i, spots[i].ln, spots[i].t, a, e);
      end else begin
        $display("spot[%0d] line %0d tick %0d = %h ok", i, spots[i].ln, spots[i].t, a);
      end
    end

    check_idle(0);
    for (int k = 1; k <= 5; k++) check_stream(k);
    check_idle(7);
    check_stream(8);
    check_stream(9);

    hs_pulses = 0;
    for (int t = 0; t < ntick[2]; t++)
      if (cap[2][t].hs && (t == 0 || !cap[2][t-1].hs)) hs_pulses++;
    n_checks++;
    if (hs_pulses != 2) begin
      n_fail++;
      $display("FAIL hs_pulses line 2 got %0d want 2", hs_pulses);
    end else begin
      $display("hs pulses line 2 = %0d ok", hs_pulses);
    end

    de_cnt = 0;
    for (int t = rst_tick; t < ntick[RST_LINE]; t++) if (cap[RST_LINE][t].de) de_cnt++;
    for (int t = 0; t < ntick[RST_LINE+1]; t++) if (cap[RST_LINE+1][t].de) de_cnt++;
    n_checks++;
    if (de_cnt != 0) begin
      n_fail++;
      $display("FAIL de_after_reset got %0d active ticks want 0", de_cnt);
    end else begin
      $display("de after reset quiet ok");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
